uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side byte buffer placed directly downstream of the UART receiver.
//  Captures every 1-cycle rx_ready strobe with its rx_data byte into a FIFO.
//  Presents the bytes to the consumer (CPU bus bridge / command parser) over a valid/ready handshake.
//  Reports fill level, almost-full and a sticky overflow with a saturating drop counter.
// PARAMETERS
//  DATA_W        8    byte width; matches receiver rx_data
//  DEPTH         16   entries; must be a power of 2, >= 2
//  ADDR_W        4    log2(DEPTH)
//  AFULL_THRESH  12   almost_full asserts when level >= AFULL_THRESH
// PORTS
//  clk           in   1         system clock (single clock domain, shared with the receiver)
//  rst           in   1         asynchronous, active-high reset
//  rx_data       in   DATA_W    byte from the receiver; valid only while rx_ready = 1
//  rx_ready      in   1         1-cycle write strobe from the receiver
//  out_data      out  DATA_W    head-of-FIFO byte; valid while out_valid = 1
//  out_valid     out  1         FIFO not empty
//  out_ready     in   1         consumer accepts; pop occurs when out_valid & out_ready
//  level         out  ADDR_W+1  current occupancy, 0..DEPTH
//  almost_full   out  1         level >= AFULL_THRESH
//  overflow      out  1         sticky: a byte was dropped because the FIFO was full
//  drop_count    out  8         dropped-byte count, saturates at 8'hFF
//  ovf_clr       in   1         1-cycle pulse; clears overflow and drop_count
// BEHAVIOUR
//  - Reset values:
//    - wr_ptr, rd_ptr, level: 0; out_valid: 0; almost_full: 0; overflow: 0; drop_count: 0.
//    - out_data reads as mem[0]; its value is don't-care while out_valid = 0.
//    - Memory array is not reset.
//  - Reset mid-operation discards all stored bytes immediately (asynchronous).
//    A strobe in the cycle reset deasserts is ignored.
//  - Event definitions:
//    - push = rx_ready & (level != DEPTH | pop)
//    - pop  = out_valid & out_ready
//  - Write: on push, mem[wr_ptr] <= rx_data and wr_ptr <= wr_ptr + 1, wrapping modulo DEPTH.
//  - Read: out_data = mem[rd_ptr] (first-word fall-through, combinational read).
//    On pop, rd_ptr <= rd_ptr + 1, wrapping modulo DEPTH.
//  - Latency: a byte strobed at edge N is visible (out_valid = 1, out_data = byte) in cycle N+1.
//    No bypass in the empty cycle.
//  - Level update:
//    - +1 on push only; -1 on pop only.
//    - Unchanged on push & pop, or neither.
//    - level, out_valid and almost_full are all registered or derived from registered state.
//  - Boundary: full, rx_ready & pop in the same cycle -> byte accepted, level stays DEPTH, no overflow.
//  - Boundary: full, rx_ready without pop -> byte dropped.
//    overflow <= 1; drop_count <= drop_count + 1, saturating at 8'hFF.
//    FIFO contents are untouched.
//  - Boundary: empty -> pop is impossible.
//    out_ready is ignored; pointers do not move.
//  - ovf_clr alone clears overflow and drop_count on the next edge.
//  - ovf_clr in the same cycle as a drop:
//    - the drop wins: overflow = 1, drop_count = 1;
//    - the event is never lost.
//  - out_valid and out_data must stay stable until pop (AXI-style rule); the producer side has no backpressure.
// STRUCTURE
//  - uart_pkg holds UART_DATA_W = 8 and the shared default depth/threshold constants.
//  - uart_pkg also holds the drop-counter width, used by the receiver, transmitter and both FIFOs.
//  - Sub-module uart_fifo_mem: DEPTH x DATA_W array with one synchronous write port and one asynchronous read port.
//  - Pointer, level and flag logic stays in uart_rx_fifo.
// TESTING
//  - After reset, level = 0, out_valid = 0 and all flags are 0.
//    Strobe 8'hA5 -> next cycle out_valid = 1, out_data = 8'hA5, level = 1.
//  - Strobe 8'h01..8'h10 (16 bytes) with out_ready = 0.
//    -> level = 16; almost_full rises on the 12th push; overflow = 0.
//    Then drain: bytes come out in order 8'h01..8'h10, and out_valid drops after the 16th pop.
//  - With the FIFO full, send 3 more strobes with out_ready = 0.
//    -> overflow = 1, drop_count = 3, head still 8'h01.
//    Pulse ovf_clr -> overflow = 0, drop_count = 0.
//  - With the FIFO full, strobe 8'h77 in the same cycle as a pop.
//    -> level stays 16, overflow = 0, and 8'h77 is the last byte drained.
//  - Wrap-around: 40 bytes streamed with a random out_ready pattern.
//    -> consumer order matches producer order; level never exceeds 16; no drops while draining fast enough.
//  - Assert rst while level = 5 and mid-pop.
//    -> level = 0 and out_valid = 0 asynchronously.
//    A post-reset strobe of 8'h3C is the only byte read.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: byte width, default FIFO geometry, drop-counter
// width and a saturating increment helper used by the receive/transmit FIFOs.
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_FIFO_DEPTH   = 16;
  localparam int UART_FIFO_ADDR_W  = 4;
  localparam int UART_AFULL_THRESH = 12;
  localparam int UART_DROP_CNT_W   = 8;

  typedef logic [UART_DATA_W-1:0]     uart_byte_t;
  typedef logic [UART_DROP_CNT_W-1:0] uart_drop_cnt_t;

  // Increment that sticks at all-ones instead of wrapping back to zero.
  function automatic uart_drop_cnt_t sat_inc(input uart_drop_cnt_t v);
    if (v == {UART_DROP_CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + UART_DROP_CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART FIFOs: one synchronous write port and one
// asynchronous read port so the consumer sees the head byte with no delay.
module uart_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Write port: contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver. Captures each rx_ready
// strobe, hands bytes out over valid/ready (first-word fall-through), and
// reports level, almost-full and a sticky overflow with a saturating drop count.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W       = UART_DATA_W,
  parameter int DEPTH        = UART_FIFO_DEPTH,
  parameter int ADDR_W       = UART_FIFO_ADDR_W,
  parameter int AFULL_THRESH = UART_AFULL_THRESH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          rx_data,
  input  logic                       rx_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W:0]            level,
  output logic                       almost_full,
  output logic                       overflow,
  output logic [UART_DROP_CNT_W-1:0] drop_count,
  input  logic                       ovf_clr
);

  localparam logic [ADDR_W:0] LVL_FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LVL_AFULL = (ADDR_W+1)'(AFULL_THRESH);
  localparam logic [ADDR_W:0] LVL_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LVL_ZERO  = (ADDR_W+1)'(0);

  logic [ADDR_W-1:0]          wr_ptr_r;
  logic [ADDR_W-1:0]          rd_ptr_r;
  logic [ADDR_W:0]            level_r;
  logic                       valid_r;
  logic                       afull_r;
  logic                       ovf_r;
  uart_drop_cnt_t             drop_cnt_r;

  logic                       full_s;
  logic                       pop_s;
  logic                       push_s;
  logic                       drop_s;
  logic [ADDR_W:0]            level_nxt_s;
  logic                       ovf_nxt_s;
  uart_drop_cnt_t             drop_cnt_nxt_s;

  // Handshake events: a full FIFO still accepts a byte when the head leaves
  // in the same cycle; only an unaccompanied strobe while full is dropped.
  always_comb begin
    full_s = (level_r == LVL_FULL);
    pop_s  = valid_r & out_ready;
    push_s = rx_ready & (~full_s | pop_s);
    drop_s = rx_ready & full_s & ~pop_s;
  end

  // Next occupancy: push and pop together leave the level unchanged.
  always_comb begin
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  // Overflow bookkeeping: a drop always wins over a simultaneous clear so the
  // event is never lost; in that case the count restarts at one.
  always_comb begin
    ovf_nxt_s      = ovf_r;
    drop_cnt_nxt_s = drop_cnt_r;
    if (drop_s) begin
      ovf_nxt_s = 1'b1;
      if (ovf_clr) begin
        drop_cnt_nxt_s = UART_DROP_CNT_W'(1);
      end else begin
        drop_cnt_nxt_s = sat_inc(drop_cnt_r);
      end
    end else if (ovf_clr) begin
      ovf_nxt_s      = 1'b0;
      drop_cnt_nxt_s = '0;
    end else begin
      ovf_nxt_s      = ovf_r;
      drop_cnt_nxt_s = drop_cnt_r;
    end
  end

  // Pointer registers, wrapping naturally modulo the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
      end
    end
  end

  // Level and the flags derived from it, registered from the next level so
  // they change in the same cycle as the occupancy they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_r <= '0;
      valid_r <= 1'b0;
      afull_r <= 1'b0;
    end else begin
      level_r <= level_nxt_s;
      valid_r <= (level_nxt_s != LVL_ZERO);
      afull_r <= (level_nxt_s >= LVL_AFULL);
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r      <= 1'b0;
      drop_cnt_r <= '0;
    end else begin
      ovf_r      <= ovf_nxt_s;
      drop_cnt_r <= drop_cnt_nxt_s;
    end
  end

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (rx_data),
    .raddr (rd_ptr_r),
    .rdata (out_data)
  );

  assign out_valid   = valid_r;
  assign level       = level_r;
  assign almost_full = afull_r;
  assign overflow    = ovf_r;
  assign drop_count  = drop_cnt_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo. A queue-based reference model
// predicts contents, level and overflow state; every cycle the DUT outputs are
// compared against it, plus directed checks for the documented scenarios.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] level;
  logic       almost_full;
  logic       overflow;
  logic [7:0] drop_count;
  logic       ovf_clr;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0] mq[$];
  bit         m_ovf;
  int         m_dc;
  int         max_level;
  int         pushed;
  logic [7:0] last_out;

  uart_rx_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .level       (level),
    .almost_full (almost_full),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("level", 32'(level), 32'(mq.size()));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= 12));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_dc));
    if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
    if (int'(level) > max_level) max_level = int'(level);
  endtask

  // One clock with the currently driven inputs; model advances in step.
  task automatic cycle();
    bit pop, full, push, drop;
    pop  = (mq.size() != 0) && out_ready;
    full = (mq.size() == 16);
    push = rx_ready && (!full || pop);
    drop = rx_ready && full && !pop;
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back(rx_data);
      pushed++;
    end
    if (drop) begin
      m_ovf = 1'b1;
      m_dc  = ovf_clr ? 1 : ((m_dc == 255) ? 255 : m_dc + 1);
    end else if (ovf_clr) begin
      m_ovf = 1'b0;
      m_dc  = 0;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_ready = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    m_ovf = 1'b0; m_dc = 0; max_level = 0; pushed = 0; last_out = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_flags", {29'd0, almost_full, overflow, |drop_count}, 32'd0);
    cycle();

    // Single byte latency
    rx_ready = 1'b1; rx_data = 8'hA5;
    cycle();
    rx_ready = 1'b0;
    chk("a5_data", 32'(out_data), 32'h0000_00A5);
    chk("a5_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("a5_drained", 32'(out_valid), 32'd0);

    // Fill 01..10 with no consumer
    for (int i = 1; i <= 16; i++) begin
      rx_ready = 1'b1; rx_data = 8'(i);
      cycle();
      chk("afull_ramp", 32'(almost_full), 32'(i >= 12));
    end
    rx_ready = 1'b0;
    chk("full_level", 32'(level), 32'd16);
    chk("full_no_ovf", 32'(overflow), 32'd0);

    // Three dropped strobes
    for (int i = 0; i < 3; i++) begin
      rx_ready = 1'b1; rx_data = 8'hE0 + 8'(i);
      cycle();
    end
    rx_ready = 1'b0;
    chk("drop3_ovf", 32'(overflow), 32'd1);
    chk("drop3_cnt", 32'(drop_count), 32'd3);
    chk("drop3_head", 32'(out_data), 32'h0000_0001);

    // Drop and clear in the same cycle: drop wins, count restarts at 1
    rx_ready = 1'b1; rx_data = 8'hEE; ovf_clr = 1'b1;
    cycle();
    rx_ready = 1'b0; ovf_clr = 1'b0;
    chk("dropclr_ovf", 32'(overflow), 32'd1);
    chk("dropclr_cnt", 32'(drop_count), 32'd1);

    // Clear alone
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_cnt", 32'(drop_count), 32'd0);

    // Full: strobe with a simultaneous pop is accepted
    rx_ready = 1'b1; rx_data = 8'h77; out_ready = 1'b1;
    cycle();
    rx_ready = 1'b0;
    chk("pp_level", 32'(level), 32'd16);
    chk("pp_ovf", 32'(overflow), 32'd0);
    chk("pp_head", 32'(out_data), 32'h0000_0002);

    // Drain everything, remembering the last byte seen
    for (int i = 0; i < 16; i++) begin
      last_out = out_data;
      cycle();
    end
    out_ready = 1'b0;
    chk("last_drained", 32'(last_out), 32'h0000_0077);
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Empty: out_ready ignored
    out_ready = 1'b1;
    cycle();
    cycle();
    out_ready = 1'b0;

    // Randomized wrap-around streaming
    pushed = 0; max_level = 0;
    for (int c = 0; c < 600 && pushed < 40; c++) begin
      rx_ready  = ($urandom_range(0, 1) == 1);
      rx_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rx_ready = 1'b0;
    chk("stream_count", 32'(pushed >= 40), 32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 40 && mq.size() != 0; c++) cycle();
    out_ready = 1'b0;
    chk("stream_empty", 32'(out_valid), 32'd0);
    chk("stream_maxlvl", 32'(max_level <= 16), 32'd1);

    // Asynchronous reset with level 5 and a pop in progress
    for (int i = 0; i < 5; i++) begin
      rx_ready = 1'b1; rx_data = 8'h50 + 8'(i);
      cycle();
    end
    rx_ready = 1'b0;
    chk("pre_rst_level", 32'(level), 32'd5);
    out_ready = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    mq.delete(); m_ovf = 1'b0; m_dc = 0;
    out_ready = 1'b0; rx_ready = 1'b1; rx_data = 8'hEE;
    @(posedge clk);
    #1;
    rst = 1'b0; rx_ready = 1'b0;
    chk("rst_strobe_ign", 32'(level), 32'd0);
    cycle();
    rx_ready = 1'b1; rx_data = 8'h3C;
    cycle();
    rx_ready = 1'b0;
    chk("post_rst_data", 32'(out_data), 32'h0000_003C);
    chk("post_rst_level", 32'(level), 32'd1);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("post_rst_empty", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
